// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT transpose buffer.
// An 8x8 block of 24-bit sign-magnitude coefficients is held between the
// row pass and the column pass of the 2D DCT.
package dct_pkg;

    localparam int N     = 8;
    localparam int W     = 24;
    localparam int IDX_W = 3;

    localparam logic [IDX_W-1:0] FIRST_IDX  = 3'd0;
    localparam logic [IDX_W-1:0] PENULT_IDX = 3'd6;
    localparam logic [IDX_W-1:0] LAST_IDX   = 3'd7;

    typedef logic [W-1:0]   coef_t;
    typedef logic [N*W-1:0] vec_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/dct_tb_bank.sv
// One NxN storage bank of coefficients.
// Rows are written whole; columns are read through a combinational mux so the
// column output follows rd_col immediately. Contents clear on reset so an
// empty bank reads as all zeros.
module dct_tb_bank
    import dct_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_row,
    input  logic [N*W-1:0]   wr_data,
    input  logic [IDX_W-1:0] rd_col,
    output logic [N*W-1:0]   rd_data
);

    coef_t mem [N][N];

    // Store an incoming row; element c of the row lands in column c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_row][c] <= wr_data[c*W +: W];
            end
        end
    end

    // Gather column rd_col, row r of the block going to element slot r.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < N; r++) begin
            rd_data[r*W +: W] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Transpose stage between the row and column passes of the 8x8 2D DCT.
// Accepts one row per beat, then emits the block's columns one per beat.
// Coefficient bits are passed through untouched.
// Optional build macro DCT_TB_PINGPONG_EN: two banks so that filling one
// block overlaps with draining the previous one. Without it a single bank
// alternates between a FILL phase and a DRAIN phase.
module dct_transpose_buffer
    import dct_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   out_col,
    output logic [IDX_W-1:0] out_col_idx,
    output logic             out_last
);

    logic [IDX_W-1:0] wr_row;
    logic [IDX_W-1:0] rd_col;
    logic             write_fire;
    logic             read_fire;

    assign write_fire  = in_valid && in_ready;
    assign read_fire   = out_valid && out_ready;
    assign out_col_idx = rd_col;

`ifdef DCT_TB_PINGPONG_EN

    logic [1:0]     full;
    logic           wbank;
    logic           rbank;
    logic [N*W-1:0] bank_col [2];

    // Handshakes come straight from the bank occupancy flags; neither looks at
    // the opposite side's ready, and the read side never depends on out_ready.
    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign out_last  = full[rbank] && (rd_col == LAST_IDX);
    assign out_col   = rbank ? bank_col[1] : bank_col[0];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tb_bank u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (write_fire && (wbank == b[0])),
            .wr_row  (wr_row),
            .wr_data (in_row),
            .rd_col  (rd_col),
            .rd_data (bank_col[b])
        );
    end

    // Write and read pointers advance independently; a completed block hands
    // its bank to the reader and a drained block hands it back to the writer.
    // A set and a clear in the same cycle always target different banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 2'b00;
            wbank  <= 1'b0;
            rbank  <= 1'b0;
            wr_row <= FIRST_IDX;
            rd_col <= FIRST_IDX;
        end else begin
            if (write_fire) begin
                if (wr_row == LAST_IDX) begin
                    wr_row      <= FIRST_IDX;
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            if (read_fire) begin
                if (rd_col == LAST_IDX) begin
                    rd_col      <= FIRST_IDX;
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end
        end
    end

`else

    state_t state;

    dct_tb_bank u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (write_fire),
        .wr_row  (wr_row),
        .wr_data (in_row),
        .rd_col  (rd_col),
        .rd_data (out_col)
    );

    // FILL collects eight rows, DRAIN hands out eight columns; handshake
    // outputs are registered alongside the state so they switch with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_row    <= FIRST_IDX;
            rd_col    <= FIRST_IDX;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (write_fire) begin
                        if (wr_row == LAST_IDX) begin
                            wr_row    <= FIRST_IDX;
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                        end else begin
                            wr_row <= wr_row + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (read_fire) begin
                        if (rd_col == LAST_IDX) begin
                            rd_col    <= FIRST_IDX;
                            state     <= FILL;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_col   <= rd_col + 1'b1;
                            out_last <= (rd_col == PENULT_IDX);
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

`endif

endmodule
